// File: rtl/bfp_pkg.sv
// Shared block-floating-point types: quant bit range, buffered sample entry
// and the finalize stage state encoding.
package bfp_pkg;

    localparam int QB_W     = 6;
    localparam int QB_MIN   = -32;
    localparam int QB_MAX   = 31;
    localparam int SAMPLE_W = 16;

    typedef logic signed [QB_W-1:0] qbit_t;

    typedef struct packed {
        logic [SAMPLE_W-1:0] value;
        qbit_t               qbit;
    } bfp_sample_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        LATCH,
        DRAIN
    } finalize_state_t;

endpackage

// File: rtl/bfp_align_shift.sv
// Aligns one sample to a common block exponent by arithmetic right shift,
// saturating to pure sign fill once the shift reaches the sample width.
module bfp_align_shift
    import bfp_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] value_i,
    input  qbit_t        q_i,
    input  qbit_t        qmax_i,
    output logic [W-1:0] value_o
);

    logic signed [QB_W:0] sh;

    // A negative distance can only come from a protocol violation; it is treated as no shift.
    always_comb begin
        sh      = $signed({qmax_i[QB_W-1], qmax_i}) - $signed({q_i[QB_W-1], q_i});
        value_o = value_i;
        if (int'(sh) >= W) begin
            value_o = {W{value_i[W-1]}};
        end else if (sh > 0) begin
            value_o = $signed(value_i) >>> sh[QB_W-1:0];
        end
    end

endmodule

// File: rtl/block_rescale_finalize.sv
// Finalize stage of block rescaling: buffers one prepared block, captures the
// final block maximum and streams every sample re-aligned to that exponent.
module block_rescale_finalize
    import bfp_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stage_1_start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in,
    input  logic [5:0]   in_quant_bit,
    input  logic         in_last,
    input  logic [5:0]   quant_bits_max,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out,
    output logic [5:0]   out_quant_bit,
    output logic         out_last,
    output logic         overflow,
    output logic         busy
);

    typedef struct packed {
        logic [W-1:0] value;
        qbit_t        qbit;
    } entry_t;

    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    entry_t          mem_q [DEPTH];
    entry_t          rd_entry;
    finalize_state_t state_q, state_d;
    logic [AW:0]     wr_cnt_q, wr_cnt_d;
    logic [AW:0]     rd_cnt_q, rd_cnt_d;
    logic [AW:0]     last_idx;
    logic [AW-1:0]   wr_addr;
    qbit_t           qmax_q, qmax_d;
    qbit_t           out_qb_q, out_qb_d;
    logic [W-1:0]    out_q, out_d;
    logic [W-1:0]    aligned;
    logic            overflow_q, overflow_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic            xfer, full, load, wr_en, drain_done;

    assign xfer       = in_valid && in_ready && !stage_1_start;
    assign full       = (wr_cnt_q == CNT_FULL);
    assign load       = (state_q == DRAIN) && (!out_valid_q || out_ready);
    assign last_idx   = wr_cnt_q - CNT_ONE;
    assign drain_done = load && (rd_cnt_q == last_idx);
    assign wr_en      = xfer && ((state_q == IDLE) || !full);
    assign wr_addr    = (state_q == IDLE) ? '0 : wr_cnt_q[AW-1:0];
    assign rd_entry   = mem_q[rd_cnt_q[AW-1:0]];

    bfp_align_shift #(.W(W)) u_align (
        .value_i (rd_entry.value),
        .q_i     (rd_entry.qbit),
        .qmax_i  (qmax_q),
        .value_o (aligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stage_1_start) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (xfer) state_d = in_last ? LATCH : FILL;
                FILL:    if (xfer && in_last) state_d = LATCH;
                LATCH:   state_d = DRAIN;
                DRAIN:   if (drain_done) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = (state_q == IDLE) || (state_q == FILL);
        busy     = (state_q != IDLE);
    end

    // The buffer has no reset; stale entries are never read before being rewritten.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= '{value: in, qbit: qbit_t'(in_quant_bit)};
        end
    end

    // A transfer beyond DEPTH is dropped but still counts for in_last, so the block drains DEPTH samples.
    always_comb begin
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        qmax_d      = qmax_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_d       = out_q;
        out_qb_d    = out_qb_q;
        if (stage_1_start) begin
            wr_cnt_d    = '0;
            rd_cnt_d    = '0;
            overflow_d  = 1'b0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            if (xfer) begin
                if (state_q == IDLE) begin
                    wr_cnt_d = CNT_ONE;
                end else if (full) begin
                    overflow_d = 1'b1;
                end else begin
                    wr_cnt_d = wr_cnt_q + CNT_ONE;
                end
            end
            if (state_q == LATCH) begin
                qmax_d   = qbit_t'(quant_bits_max);
                rd_cnt_d = '0;
            end
            if (load) begin
                out_d       = aligned;
                out_qb_d    = qmax_q;
                out_last_d  = drain_done;
                out_valid_d = 1'b1;
                rd_cnt_d    = rd_cnt_q + CNT_ONE;
            end else if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            qmax_q      <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_q       <= '0;
            out_qb_q    <= '0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            qmax_q      <= qmax_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_q       <= out_d;
            out_qb_q    <= out_qb_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_last      = out_last_q;
    assign out           = out_q;
    assign out_quant_bit = out_qb_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_block_rescale_finalize.sv
// Bench for block_rescale_finalize: drives prepared blocks and compares the
// streamed output against a floor-division model of exponent alignment.
module tb_block_rescale_finalize;

    localparam int W     = 16;
    localparam int DEPTH = 64;

    typedef struct {
        logic [15:0] v;
        logic [5:0]  qb;
        logic        last;
    } obs_t;

    logic        clk;
    logic        rst_n;
    logic        stage_1_start;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [5:0]  in_qb;
    logic        in_last;
    logic [5:0]  quant_bits_max;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [5:0]  out_quant_bit;
    logic        out_last;
    logic        overflow;
    logic        busy;

    int          checks;
    int          errors;
    logic [15:0] blkV[$];
    int          blkQ[$];
    logic [15:0] expV[$];
    obs_t        obs_q[$];
    int          holdBad;
    int          inReadyBad;
    int          firstValid;
    bit          timedOut;

    block_rescale_finalize #(.W(W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stage_1_start  (stage_1_start),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in             (in_data),
        .in_quant_bit   (in_qb),
        .in_last        (in_last),
        .quant_bits_max (quant_bits_max),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out            (out_data),
        .out_quant_bit  (out_quant_bit),
        .out_last       (out_last),
        .overflow       (overflow),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Value of sample * 2^-(qmax-q), rounded toward minus infinity.
    function automatic logic [15:0] refAlign(input logic [15:0] v, input int q, input int qmax);
        int sh;
        int sv;
        int p;
        int r;
        sh = qmax - q;
        sv = $signed(v);
        if (sh <= 0) begin
            r = sv;
        end else if (sh >= 16) begin
            r = (sv < 0) ? -1 : 0;
        end else begin
            p = 1 << sh;
            r = (sv >= 0) ? sv / p : -((-sv + p - 1) / p);
        end
        return 16'(r);
    endfunction

    task automatic applyStimulus(input logic [15:0] v, input int q, input logic last);
        in_valid = 1'b1;
        in_data  = v;
        in_qb    = 6'(q);
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic sendBlock(input int qmax);
        quant_bits_max = 6'(qmax);
        for (int i = 0; i < blkV.size(); i++) begin
            applyStimulus(blkV[i], blkQ[i], (i == blkV.size() - 1));
        end
    endtask

    task automatic buildExpected(input int qmax);
        expV.delete();
        for (int i = 0; i < blkV.size() && i < DEPTH; i++) begin
            expV.push_back(refAlign(blkV[i], blkQ[i], qmax));
        end
    endtask

    task automatic makeRandomBlock(input int n, output int qmax);
        int span;
        blkV.delete();
        blkQ.delete();
        qmax = int'($urandom_range(63)) - 32;
        for (int i = 0; i < n; i++) begin
            span = qmax + 32;
            if ($urandom_range(3) != 0 && span > 20) span = 20;
            blkV.push_back(16'($urandom));
            blkQ.push_back(qmax - int'($urandom_range(span)));
        end
    endtask

    // mode 0: ready held high, 1: ready pattern 1,0,0,1,0,1,..., 2: random ready
    task automatic collectOutput(input int mode, input int stopAfter, input int maxCycles);
        logic [5:0] patt;
        obs_t       cur;
        obs_t       held;
        bit         haveHeld;
        patt     = 6'b101001;
        haveHeld = 0;
        obs_q.delete();
        holdBad    = 0;
        inReadyBad = 0;
        firstValid = -1;
        timedOut   = 0;
        for (int cyc = 0; cyc <= maxCycles; cyc++) begin
            if (cyc == maxCycles) begin
                timedOut  = 1;
                out_ready = 1'b0;
                break;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = patt[cyc % 6];
                default: out_ready = 1'($urandom_range(1));
            endcase
            cur.v    = out_data;
            cur.qb   = out_quant_bit;
            cur.last = out_last;
            if (haveHeld && (out_valid !== 1'b1 || cur.v !== held.v ||
                             cur.qb !== held.qb || cur.last !== held.last)) holdBad++;
            haveHeld = 0;
            if (out_valid === 1'b1) begin
                if (firstValid < 0) firstValid = cyc;
                if (out_last !== 1'b1 && in_ready !== 1'b0) inReadyBad++;
                if (out_ready) begin
                    obs_q.push_back(cur);
                    if (cur.last === 1'b1 || obs_q.size() == stopAfter) begin
                        @(posedge clk); #1;
                        out_ready = 1'b0;
                        break;
                    end
                end else begin
                    held     = cur;
                    haveHeld = 1;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stage_1_start = 1'b0; in_valid = 1'b0; in_data = '0; in_qb = '0;
        in_last = 1'b0; quant_bits_max = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags got busy=%b ov=%b ol=%b ovf=%b want all 0", busy, out_valid, out_last, overflow);
        end
        checks++;
        if (out_data !== 16'h0000 || out_quant_bit !== 6'h00) begin
            errors++;
            $display("[TB] FAIL reset_data got %h/%h want 0000/00", out_data, out_quant_bit);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle got in_ready=%b busy=%b want 1/0", in_ready, busy);
        end
    endtask

    task automatic test_basic();
        blkV = '{16'h0100, 16'h0200, 16'h8000};
        blkQ = '{-4, -2, 0};
        sendBlock(0);
        buildExpected(0);
        collectOutput(0, 0, 50);
        checks++;
        if (firstValid != 2) begin
            errors++;
            $display("[TB] FAIL basic_latency got %0d want 2", firstValid);
        end
        checks++;
        if (timedOut || obs_q.size() != expV.size()) begin
            errors++;
            $display("[TB] FAIL basic_count got %0d want %0d", obs_q.size(), expV.size());
        end
        for (int i = 0; i < obs_q.size() && i < expV.size(); i++) begin
            checks++;
            if (obs_q[i].v !== expV[i] || obs_q[i].qb !== 6'd0 || obs_q[i].last !== (i == expV.size() - 1)) begin
                errors++;
                $display("[TB] FAIL basic_s%0d got %h/%h/%b want %h/00/%b", i, obs_q[i].v, obs_q[i].qb, obs_q[i].last, expV[i], (i == expV.size() - 1));
            end
        end
    endtask

    task automatic test_saturate();
        blkV = '{16'hFF00, 16'h7FFF, 16'h8000, 16'h1234};
        blkQ = '{-8, -32, -32, 31};
        sendBlock(31);
        buildExpected(31);
        collectOutput(0, 0, 50);
        checks++;
        if (timedOut || obs_q.size() != expV.size()) begin
            errors++;
            $display("[TB] FAIL sat_count got %0d want %0d", obs_q.size(), expV.size());
        end
        for (int i = 0; i < obs_q.size() && i < expV.size(); i++) begin
            checks++;
            if (obs_q[i].v !== expV[i] || obs_q[i].qb !== 6'd31 || obs_q[i].last !== (i == expV.size() - 1)) begin
                errors++;
                $display("[TB] FAIL sat_s%0d got %h/%h/%b want %h/1f/%b", i, obs_q[i].v, obs_q[i].qb, obs_q[i].last, expV[i], (i == expV.size() - 1));
            end
        end
    endtask

    task automatic test_backpressure();
        int qm;
        makeRandomBlock(4, qm);
        sendBlock(qm);
        buildExpected(qm);
        collectOutput(1, 0, 100);
        checks++;
        if (holdBad != 0 || inReadyBad != 0) begin
            errors++;
            $display("[TB] FAIL bp_stall got hold=%0d inready=%0d want 0/0", holdBad, inReadyBad);
        end
        checks++;
        if (timedOut || obs_q.size() != expV.size()) begin
            errors++;
            $display("[TB] FAIL bp_count got %0d want %0d", obs_q.size(), expV.size());
        end
        for (int i = 0; i < obs_q.size() && i < expV.size(); i++) begin
            checks++;
            if (obs_q[i].v !== expV[i] || obs_q[i].qb !== 6'(qm) || obs_q[i].last !== (i == expV.size() - 1)) begin
                errors++;
                $display("[TB] FAIL bp_s%0d got %h/%h/%b want %h/%h/%b", i, obs_q[i].v, obs_q[i].qb, obs_q[i].last, expV[i], 6'(qm), (i == expV.size() - 1));
            end
        end
    endtask

    task automatic test_overflow();
        int qm;
        makeRandomBlock(DEPTH + 2, qm);
        sendBlock(qm);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_set got %b want 1", overflow);
        end
        buildExpected(qm);
        collectOutput(0, 0, DEPTH + 20);
        checks++;
        if (timedOut || obs_q.size() != DEPTH) begin
            errors++;
            $display("[TB] FAIL ovf_count got %0d want %0d", obs_q.size(), DEPTH);
        end
        for (int i = 0; i < obs_q.size() && i < expV.size(); i++) begin
            checks++;
            if (obs_q[i].v !== expV[i] || obs_q[i].qb !== 6'(qm) || obs_q[i].last !== (i == expV.size() - 1)) begin
                errors++;
                $display("[TB] FAIL ovf_s%0d got %h/%h/%b want %h/%h/%b", i, obs_q[i].v, obs_q[i].qb, obs_q[i].last, expV[i], 6'(qm), (i == expV.size() - 1));
            end
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_sticky got %b want 1", overflow);
        end
        stage_1_start = 1'b1;
        @(posedge clk); #1;
        stage_1_start = 1'b0;
        checks++;
        if (overflow !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_clear got ovf=%b busy=%b want 0/0", overflow, busy);
        end
    endtask

    task automatic test_single_back_to_back();
        int qm;
        blkV = '{16'hABCD};
        blkQ = '{5};
        sendBlock(5);
        collectOutput(0, 0, 20);
        checks++;
        if (timedOut || obs_q.size() != 1 || obs_q[0].v !== 16'hABCD || obs_q[0].qb !== 6'd5 || obs_q[0].last !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single got n=%0d %h/%h/%b want n=1 abcd/05/1", obs_q.size(),
                     out_data, out_quant_bit, out_last);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_ready got %b want 1", in_ready);
        end
        makeRandomBlock(3, qm);
        quant_bits_max = 6'(qm);
        applyStimulus(blkV[0], blkQ[0], 1'b0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_accept got busy=%b want 1", busy);
        end
        applyStimulus(blkV[1], blkQ[1], 1'b0);
        applyStimulus(blkV[2], blkQ[2], 1'b1);
        buildExpected(qm);
        collectOutput(0, 0, 30);
        checks++;
        if (timedOut || obs_q.size() != expV.size()) begin
            errors++;
            $display("[TB] FAIL b2b_count got %0d want %0d", obs_q.size(), expV.size());
        end
        for (int i = 0; i < obs_q.size() && i < expV.size(); i++) begin
            checks++;
            if (obs_q[i].v !== expV[i] || obs_q[i].qb !== 6'(qm) || obs_q[i].last !== (i == expV.size() - 1)) begin
                errors++;
                $display("[TB] FAIL b2b_s%0d got %h/%h/%b want %h/%h/%b", i, obs_q[i].v, obs_q[i].qb, obs_q[i].last, expV[i], 6'(qm), (i == expV.size() - 1));
            end
        end
    endtask

    task automatic test_abort();
        int qm;
        bit seen;
        makeRandomBlock(5, qm);
        sendBlock(qm);
        buildExpected(qm);
        collectOutput(0, 2, 30);
        checks++;
        if (timedOut || obs_q.size() != 2) begin
            errors++;
            $display("[TB] FAIL abort_pre_count got %0d want 2", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < 2; i++) begin
            checks++;
            if (obs_q[i].v !== expV[i] || obs_q[i].last !== 1'b0) begin
                errors++;
                $display("[TB] FAIL abort_s%0d got %h/%b want %h/0", i, obs_q[i].v, obs_q[i].last, expV[i]);
            end
        end
        stage_1_start = 1'b1;
        out_ready     = 1'b1;
        @(posedge clk); #1;
        stage_1_start = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_stop got ov=%b busy=%b ol=%b want 0/0/0", out_valid, busy, out_last);
        end
        seen = 0;
        repeat (4) begin
            if (out_valid !== 1'b0) seen = 1;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        checks++;
        if (seen) begin
            errors++;
            $display("[TB] FAIL abort_quiet got out_valid=1 want 0");
        end
        makeRandomBlock(4, qm);
        sendBlock(qm);
        buildExpected(qm);
        collectOutput(0, 0, 30);
        checks++;
        if (timedOut || obs_q.size() != expV.size()) begin
            errors++;
            $display("[TB] FAIL abort_new_count got %0d want %0d", obs_q.size(), expV.size());
        end
        for (int i = 0; i < obs_q.size() && i < expV.size(); i++) begin
            checks++;
            if (obs_q[i].v !== expV[i] || obs_q[i].qb !== 6'(qm) || obs_q[i].last !== (i == expV.size() - 1)) begin
                errors++;
                $display("[TB] FAIL abort_new_s%0d got %h/%h/%b want %h/%h/%b", i, obs_q[i].v, obs_q[i].qb, obs_q[i].last, expV[i], 6'(qm), (i == expV.size() - 1));
            end
        end
    endtask

    task automatic test_reset_midfill();
        int qm;
        makeRandomBlock(6, qm);
        quant_bits_max = 6'(qm);
        for (int i = 0; i < 3; i++) applyStimulus(blkV[i], blkQ[i], 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || overflow !== 1'b0 ||
            out_data !== 16'h0000 || out_quant_bit !== 6'h00) begin
            errors++;
            $display("[TB] FAIL rst_async got busy=%b ov=%b ol=%b ovf=%b out=%h qb=%h want 0", busy, out_valid, out_last, overflow, out_data, out_quant_bit);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        makeRandomBlock(5, qm);
        sendBlock(qm);
        buildExpected(qm);
        collectOutput(0, 0, 30);
        checks++;
        if (timedOut || obs_q.size() != expV.size()) begin
            errors++;
            $display("[TB] FAIL rst_new_count got %0d want %0d", obs_q.size(), expV.size());
        end
        for (int i = 0; i < obs_q.size() && i < expV.size(); i++) begin
            checks++;
            if (obs_q[i].v !== expV[i] || obs_q[i].qb !== 6'(qm) || obs_q[i].last !== (i == expV.size() - 1)) begin
                errors++;
                $display("[TB] FAIL rst_new_s%0d got %h/%h/%b want %h/%h/%b", i, obs_q[i].v, obs_q[i].qb, obs_q[i].last, expV[i], 6'(qm), (i == expV.size() - 1));
            end
        end
    endtask

    task automatic test_random();
        int qm;
        for (int b = 0; b < 8; b++) begin
            makeRandomBlock(int'($urandom_range(12, 1)), qm);
            sendBlock(qm);
            buildExpected(qm);
            collectOutput(2, 0, 200);
            checks++;
            if (timedOut || obs_q.size() != expV.size() || holdBad != 0) begin
                errors++;
                $display("[TB] FAIL rand%0d_count got %0d hold=%0d want %0d hold=0", b, obs_q.size(), holdBad, expV.size());
            end
            for (int i = 0; i < obs_q.size() && i < expV.size(); i++) begin
                checks++;
                if (obs_q[i].v !== expV[i] || obs_q[i].qb !== 6'(qm) || obs_q[i].last !== (i == expV.size() - 1)) begin
                    errors++;
                    $display("[TB] FAIL rand%0d_s%0d got %h/%h/%b want %h/%h/%b", b, i, obs_q[i].v, obs_q[i].qb, obs_q[i].last, expV[i], 6'(qm), (i == expV.size() - 1));
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_saturate();
        test_backpressure();
        test_overflow();
        test_single_back_to_back();
        test_abort();
        test_reset_midfill();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
